// File: rtl/ber_meter.sv
// Bit-error-rate meter: aligns the reference stream to the decoder output by a
// programmable strobe delay and counts mismatches per window and in total.
//
// state   | meaning
// FILL    | history priming after reset/clear/delay change; no compares
// MEASURE | every strobe compares dec_sig against the aligned reference
module ber_meter #(
  parameter int DLY_W  = 6,
  parameter int WINDOW = 1024,
  parameter int TOT_W  = 32
) (
  input  logic             clk_sig,
  input  logic             reset_sig,
  input  logic             en_sig,
  input  logic             ref_sig,
  input  logic             dec_sig,
  input  logic [DLY_W-1:0] delay_sig,
  input  logic             clear_sig,
  output logic             meas_sig,
  output logic             win_done_sig,
  output logic [16:0]      err_cnt_sig,
  output logic [TOT_W-1:0] total_err_sig,
  output logic [TOT_W-1:0] total_bit_sig
);

  localparam int HIST_W = (1 << DLY_W) - 1;

  typedef enum logic {FILL = 1'b0, MEASURE = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [DLY_W-1:0]  delay_q;
  logic [DLY_W-1:0]  fill_cnt;
  logic [DLY_W-1:0]  tap_idx;
  logic [HIST_W-1:0] hist;
  logic [15:0]       win_bits;
  logic [16:0]       win_err;
  logic              dly_chg;
  logic              compare;
  logic              aligned;
  logic              miss;
  logic              win_last;

  assign dly_chg  = (delay_sig != delay_q);
  assign tap_idx  = delay_q - 1'b1;
  // hist[0] holds the ref bit of the previous strobe, so delay d taps hist[d-1]
  assign aligned  = (delay_q == '0) ? ref_sig : hist[tap_idx];
  assign miss     = compare && (dec_sig != aligned);
  assign win_last = compare && (win_bits == 16'(WINDOW - 1));
  assign meas_sig = (state == MEASURE);

  always_ff @(posedge clk_sig or negedge reset_sig) begin
    if (!reset_sig) state <= FILL;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    compare   = 1'b0;
    if (clear_sig || dly_chg) begin
      state_nxt = FILL;
    end else begin
      case (state)
        FILL: begin
          if (delay_q == '0)
            state_nxt = MEASURE;
          else if (en_sig && (fill_cnt == tap_idx))
            state_nxt = MEASURE;
        end
        MEASURE: compare = en_sig;
      endcase
    end
  end

  always_ff @(posedge clk_sig or negedge reset_sig) begin
    if (!reset_sig) begin
      delay_q       <= '0;
      fill_cnt      <= '0;
      hist          <= '0;
      win_bits      <= '0;
      win_err       <= '0;
      win_done_sig  <= 1'b0;
      err_cnt_sig   <= '0;
      total_err_sig <= '0;
      total_bit_sig <= '0;
    end else begin
      delay_q      <= delay_sig;
      win_done_sig <= 1'b0;
      if (clear_sig) begin
        // history deliberately survives a clear
        fill_cnt      <= '0;
        win_bits      <= '0;
        win_err       <= '0;
        err_cnt_sig   <= '0;
        total_err_sig <= '0;
        total_bit_sig <= '0;
      end else begin
        if (en_sig)
          hist <= (hist << 1) | HIST_W'(ref_sig);
        if (dly_chg) begin
          fill_cnt <= '0;
          win_bits <= '0;
          win_err  <= '0;
        end else if (state == FILL) begin
          if (en_sig)
            fill_cnt <= fill_cnt + 1'b1;
        end else if (compare) begin
          if (win_last) begin
            err_cnt_sig  <= win_err + 17'(miss);
            win_done_sig <= 1'b1;
            win_bits     <= '0;
            win_err      <= '0;
          end else begin
            win_bits <= win_bits + 1'b1;
            win_err  <= win_err + 17'(miss);
          end
          if (total_bit_sig != '1)
            total_bit_sig <= total_bit_sig + 1'b1;
          if (miss && (total_err_sig != '1))
            total_err_sig <= total_err_sig + 1'b1;
        end
      end
    end
  end

endmodule
